// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard-side serializer.
package ps2_pkg;

  typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP, HOLD} state_e;

  localparam int FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO feeding the PS/2 serializer; registered full/empty flags.
module ps2_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_wr, do_rd;

  assign do_wr = wr & ~full_q;
  assign do_rd = rd & ~empty_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_FULL);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_wr) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes and clocks them out
// as 11-bit frames, retrying a frame from its start bit after a host inhibit.
module ps2_kbd_tx #(
  parameter int HALF_PERIOD = 3200,
  parameter int GAP_HALVES  = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       inhibit,
  output logic       ps2_kbd_clk,
  output logic       ps2_kbd_data,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);
  import ps2_pkg::*;

  localparam int GAP_CYC = GAP_HALVES * HALF_PERIOD;
  localparam int TW      = (GAP_CYC > HALF_PERIOD) ? $clog2(GAP_CYC + 1) : $clog2(HALF_PERIOD + 1);
  localparam logic [TW-1:0] HP_LAST  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  state_e                  state_q;
  logic [TW-1:0]           tmr_q;
  logic [3:0]              bitcnt_q;
  logic [FRAME_BITS-2:0]   sr_q;
  logic [7:0]              hold_q;
  logic                    retry_q, clk_q, data_q, busy_q, ovf_q;
  logic [7:0]              fifo_dout, tx_byte;
  logic                    fifo_full, fifo_empty;
  logic                    tmr_done, start_ok, load, shift, pop;

  assign tmr_done = (tmr_q == '0);
  assign start_ok = ~inhibit & (retry_q | ~fifo_empty);
  assign load     = (state_q == IDLE) & start_ok;
  assign pop      = load & ~retry_q;
  assign shift    = (state_q == LOW) & tmr_done & (bitcnt_q < LAST_BIT);
  assign tx_byte  = retry_q ? hold_q : fifo_dout;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .din     (din),
    .wr      (wr),
    .rd      (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // sr_q holds the bits after the start bit; the start bit goes straight to data_q.
  always_ff @(posedge clk_sys) begin
    if (load) begin
      sr_q   <= {1'b1, odd_parity(tx_byte), tx_byte};
      hold_q <= tx_byte;
    end else if (shift) begin
      sr_q <= {1'b1, sr_q[FRAME_BITS-2:1]};
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      bitcnt_q <= '0;
      retry_q  <= 1'b0;
      clk_q    <= 1'b1;
      data_q   <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr && fifo_full) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          clk_q  <= 1'b1;
          data_q <= 1'b1;
          if (start_ok) begin
            state_q  <= HIGH;
            tmr_q    <= HP_LAST;
            bitcnt_q <= '0;
            data_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        // Inhibit only aborts before the stop bit; the stop bit always completes.
        HIGH: begin
          if (inhibit && bitcnt_q < LAST_BIT) begin
            state_q <= HOLD;
            tmr_q   <= HP_LAST;
            retry_q <= 1'b1;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
          end else if (tmr_done) begin
            state_q <= LOW;
            tmr_q   <= HP_LAST;
            clk_q   <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        LOW: begin
          if (tmr_done) begin
            clk_q <= 1'b1;
            if (bitcnt_q == LAST_BIT) begin
              state_q <= GAP;
              tmr_q   <= GAP_LAST;
              data_q  <= 1'b1;
              retry_q <= 1'b0;
            end else begin
              state_q  <= HIGH;
              tmr_q    <= HP_LAST;
              bitcnt_q <= bitcnt_q + 1'b1;
              data_q   <= sr_q[0];
            end
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        GAP: begin
          if (tmr_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        HOLD: begin
          if (inhibit) begin
            tmr_q <= HP_LAST;
          end else if (tmr_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          clk_q   <= 1'b1;
          data_q  <= 1'b1;
        end
      endcase
    end
  end

  assign ps2_kbd_clk  = clk_q;
  assign ps2_kbd_data = data_q;
  assign busy         = busy_q;
  assign full         = fifo_full;
  assign empty        = fifo_empty;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: decodes frames off the PS/2 lines at falling edges.
module tb_ps2_kbd_tx;

  localparam int HP = 4;
  localparam int GH = 4;
  localparam int DEPTH = 16;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       inhibit = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2_kbd_clk, ps2_kbd_data, busy, full, empty, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_cyc = 0;
  logic prev_clk = 1'b1;
  logic bitq[$];
  int   fallt[$];
  int   riset[$];

  typedef struct {
    logic [7:0] b;
    logic       par;
  } vec_t;
  vec_t tbl[7];

  ps2_kbd_tx #(.HALF_PERIOD(HP), .GAP_HALVES(GH), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .din          (din),
    .wr           (wr),
    .inhibit      (inhibit),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .busy         (busy),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    prev_clk <= ps2_kbd_clk;
    if (prev_clk && !ps2_kbd_clk) begin
      bitq.push_back(ps2_kbd_data);
      fallt.push_back(cyc);
    end
    if (!prev_clk && ps2_kbd_clk) riset.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input int got, input int minv);
    checks++;
    if (got < minv) begin
      errors++;
      $display("FAIL %s got %0d required >= %0d", nm, got, minv);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic clr();
    bitq.delete();
    fallt.delete();
    riset.delete();
  endtask

  task automatic wr_byte(input logic [7:0] b);
    tick();
    din = b;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
  endtask

  task automatic wait_falls(input string nm, input int n, input int budget);
    for (int i = 0; i < budget && bitq.size() < n; i++) tick();
    chk_ge({nm, "_falls"}, bitq.size(), n);
  endtask

  task automatic wait_rises(input string nm, input int n, input int budget);
    for (int i = 0; i < budget && riset.size() < n; i++) tick();
    chk_ge({nm, "_rises"}, riset.size(), n);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    idle_cyc = cyc;
    chk({nm, "_idle"}, 32'(busy), 0);
  endtask

  function automatic logic [10:0] frame_at(input int idx);
    logic [10:0] v;
    v = 'x;
    for (int k = 0; k < 11; k++)
      if (idx + k < bitq.size()) v[k] = bitq[idx + k];
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [10:0] expv;

    tbl[0] = '{8'h1C, 1'b0};
    tbl[1] = '{8'h5A, 1'b1};
    tbl[2] = '{8'h00, 1'b1};
    tbl[3] = '{8'hFF, 1'b1};
    tbl[4] = '{8'h01, 1'b0};
    tbl[5] = '{8'h80, 1'b0};
    tbl[6] = '{8'hF0, 1'b1};

    repeat (3) tick();
    chk("rst_clk", 32'(ps2_kbd_clk), 1);
    chk("rst_data", 32'(ps2_kbd_data), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single frames from the vector table.
    foreach (tbl[i]) begin
      clr();
      wr_byte(tbl[i].b);
      wait_falls($sformatf("tbl%0d", i), 11, 400);
      wait_idle($sformatf("tbl%0d", i), 200);
      chk($sformatf("tbl%0d_frame", i), 32'(frame_at(0)), 32'({1'b1, tbl[i].par, tbl[i].b, 1'b0}));
      if (i == 0 && riset.size() >= 11)
        chk("busy_fall_delay", 32'(idle_cyc - riset[10]), 32'(GH * HP));
      repeat (30) tick();
      chk($sformatf("tbl%0d_nfall", i), 32'(bitq.size()), 11);
    end

    // Back-to-back writes: the second write coincides with the first pop.
    clr();
    tick();
    din = 8'hF0;
    wr  = 1'b1;
    tick();
    din = 8'h1C;
    tick();
    wr  = 1'b0;
    wait_falls("b2b", 22, 800);
    chk("b2b_f0", 32'(frame_at(0)), 32'({1'b1, 1'b1, 8'hF0, 1'b0}));
    chk("b2b_1c", 32'(frame_at(11)), 32'({1'b1, 1'b0, 8'h1C, 1'b0}));
    if (fallt.size() >= 12 && riset.size() >= 11)
      chk_ge("b2b_gap", fallt[11] - riset[10], GH * HP + HP);
    else
      chk_ge("b2b_gap_edges", fallt.size(), 12);
    wait_idle("b2b", 300);

    // Fill while inhibited, overflow, then drain.
    clr();
    inhibit = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_byte(8'(i * 37 + 5));
      if (i == 14) chk("fill_not_full15", 32'(full), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_empty", 32'(empty), 0);
    chk("fill_ovf0", 32'(overflow), 0);
    wr_byte(8'hEE);
    chk("fill_ovf1", 32'(overflow), 1);
    chk("fill_full17", 32'(full), 1);
    chk("fill_nofall", 32'(bitq.size()), 0);
    inhibit = 1'b0;
    wait_falls("drain", 176, 4000);
    wait_idle("drain", 300);
    for (int f = 0; f < 16; f++) begin
      b = 8'(f * 37 + 5);
      expv = {1'b1, ~^b, b, 1'b0};
      chk($sformatf("drain_f%0d", f), 32'(frame_at(f * 11)), 32'(expv));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_full", 32'(full), 0);
    repeat (40) tick();
    chk("drain_nfall", 32'(bitq.size()), 176);
    chk("drain_ovf_sticky", 32'(overflow), 1);

    // Inhibit during bit 4 forces a retransmit from the start bit.
    clr();
    wr_byte(8'h5A);
    wait_rises("inh4", 4, 300);
    inhibit = 1'b1;
    tick();
    chk("inh4_clk", 32'(ps2_kbd_clk), 1);
    chk("inh4_data", 32'(ps2_kbd_data), 1);
    chk("inh4_busy", 32'(busy), 1);
    repeat (40) tick();
    chk("inh4_nfall", 32'(bitq.size()), 4);
    chk("inh4_empty", 32'(empty), 1);
    inhibit = 1'b0;
    wait_falls("inh4_retry", 15, 400);
    chk("inh4_frame", 32'(frame_at(4)), 32'({1'b1, 1'b1, 8'h5A, 1'b0}));
    wait_idle("inh4", 200);
    repeat (60) tick();
    chk("inh4_total", 32'(bitq.size()), 15);
    chk("inh4_empty2", 32'(empty), 1);

    // Inhibit during the stop bit is ignored.
    clr();
    wr_byte(8'h1C);
    wait_rises("inhs", 10, 400);
    inhibit = 1'b1;
    wait_falls("inhs", 11, 100);
    wait_idle("inhs", 200);
    chk("inhs_frame", 32'(frame_at(0)), 32'({1'b1, 1'b0, 8'h1C, 1'b0}));
    inhibit = 1'b0;
    repeat (60) tick();
    chk("inhs_nfall", 32'(bitq.size()), 11);

    // Reset in the middle of a frame.
    clr();
    inhibit = 1'b1;
    for (int i = 0; i < 17; i++) wr_byte(8'hA0 + 8'(i));
    chk("rstm_ovf_pre", 32'(overflow), 1);
    inhibit = 1'b0;
    wait_falls("rstm", 3, 200);
    for (int i = 0; i < 20 && ps2_kbd_clk; i++) tick();
    chk("rstm_clk_low", 32'(ps2_kbd_clk), 0);
    rst_n = 1'b0;
    #1;
    chk("rstm_clk", 32'(ps2_kbd_clk), 1);
    chk("rstm_data", 32'(ps2_kbd_data), 1);
    chk("rstm_busy", 32'(busy), 0);
    chk("rstm_empty", 32'(empty), 1);
    chk("rstm_full", 32'(full), 0);
    chk("rstm_ovf", 32'(overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();
    clr();
    repeat (300) tick();
    chk("rstm_nofall", 32'(bitq.size()), 0);
    chk("rstm_idle", 32'(busy), 0);
    wr_byte(8'h3C);
    wait_falls("rstm_new", 11, 400);
    chk("rstm_new_frame", 32'(frame_at(0)), 32'({1'b1, 1'b1, 8'h3C, 1'b0}));
    wait_idle("rstm_new", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
